// File: rtl/store_buffer.sv
// store_buffer: converts CPU store requests into word-aligned, lane-replicated
// writes with byte strobes, and queues them in an in-order FIFO that drains
// to the data memory over a valid/ready handshake. A store to the same word
// as the youngest queued entry is folded into that entry instead of taking a
// new slot.
module store_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [1:0]            size,
    input  logic [31:0]           data,
    output logic                  valid,
    input  logic                  ready,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [3:0]            wstrb,
    output logic [31:0]           wdata,
    output logic                  empty,
    output logic                  misalign
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WA_W  = ADDR_WIDTH - 2;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    // Queue storage: word address (bits [1:0] implied zero), strobe, data.
    logic [WA_W-1:0]  ent_addr [DEPTH];
    logic [3:0]       ent_strb [DEPTH];
    logic [31:0]      ent_data [DEPTH];

    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W-1:0] young_ptr;
    logic [CNT_W-1:0] count;

    logic [1:0]       off;
    logic [3:0]       new_strb;
    logic [31:0]      new_data;
    logic             aligned;
    logic             pop;
    logic             merge_hit;
    logic             accept;
    logic             do_push;
    logic             do_merge;

    assign off = addr[1:0];

    // Lane generation: replicate data across the word and build the strobe.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        new_strb = 4'b0000;
        new_data = data;
        aligned  = 1'b0;
        case (size_e'(size))
            SZ_BYTE: begin
                new_data = {4{data[7:0]}};
                new_strb = 4'b0001 << off;
                aligned  = 1'b1;
            end
            SZ_HALF: begin
                new_data = {2{data[15:0]}};
                new_strb = off[1] ? 4'b1100 : 4'b0011;
                aligned  = ~off[0];
            end
            SZ_WORD: begin
                new_strb = 4'b1111;
                aligned  = (off == 2'b00);
            end
            default: begin
                aligned = 1'b0;
            end
        endcase
    end

    assign valid     = (count != '0);
    assign empty     = ~valid;
    assign pop       = valid & ready;
    assign young_ptr = tail_ptr - PTR_W'(1);

    // A merge may not target the head in the same cycle it leaves the queue.
    assign merge_hit = aligned & valid
                     & (addr[ADDR_WIDTH-1:2] == ent_addr[young_ptr])
                     & ~((count == CNT_W'(1)) & pop);

    assign req_ready = (count != FULL_CNT) | merge_hit;
    assign accept    = req & req_ready;
    assign do_push   = accept & aligned & ~merge_hit;
    assign do_merge  = accept & merge_hit;

    assign waddr = {ent_addr[head_ptr], 2'b00};
    assign wstrb = ent_strb[head_ptr];
    assign wdata = ent_data[head_ptr];

    // Pointer, occupancy and misalign-pulse bookkeeping.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            misalign <= 1'b0;
        end else begin
            if (do_push) tail_ptr <= tail_ptr + PTR_W'(1);
            if (pop)     head_ptr <= head_ptr + PTR_W'(1);
            case ({do_push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            misalign <= accept & ~aligned;
        end
    end

    // Entry storage: write a new entry at the tail or merge lanes into the youngest.
    always_ff @(posedge clk) begin
        // NOTE: the entry array is deliberately not reset; an entry is only
        // ever read while count says it holds live data.
        if (do_push) begin
            ent_addr[tail_ptr] <= addr[ADDR_WIDTH-1:2];
            ent_strb[tail_ptr] <= new_strb;
            ent_data[tail_ptr] <= new_data;
        end else if (do_merge) begin
            for (int i = 0; i < 4; i++) begin
                if (new_strb[i]) ent_data[young_ptr][8*i +: 8] <= new_data[8*i +: 8];
            end
            ent_strb[young_ptr] <= ent_strb[young_ptr] | new_strb;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: directed scenarios plus randomized traffic,
// checked against a queue-based reference model of the pending writes.
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          req_ready;
    logic [AW-1:0] addr;
    logic [1:0]    size;
    logic [31:0]   data;
    logic          valid;
    logic          ready;
    logic [AW-1:0] waddr;
    logic [3:0]    wstrb;
    logic [31:0]   wdata;
    logic          empty;
    logic          misalign;

    store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_ready(req_ready),
        .addr(addr), .size(size), .data(data), .valid(valid), .ready(ready),
        .waddr(waddr), .wstrb(wstrb), .wdata(wdata), .empty(empty),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] waddr;
        logic [3:0]  strb;
        logic [31:0] data;
    } ent_t;

    ent_t mq[$];          // pending writes in program order, oldest first
    logic exp_mis = 1'b0;
    bit   started = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   writes   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT state with the model and retires each handshake.
    always @(negedge clk) begin
        if (started) begin
            check("valid", 32'(valid), 32'(mq.size() != 0));
            check("empty", 32'(empty), 32'(mq.size() == 0));
            check("misalign", 32'(misalign), 32'(exp_mis));
            if (valid && ready && mq.size() != 0) begin
                check("waddr", waddr, mq[0].waddr);
                check("wstrb", 32'(wstrb), 32'(mq[0].strb));
                check("wdata", wdata, mq[0].data);
                void'(mq.pop_front());
                writes++;
            end
        end
    end

    // One cycle of stimulus; predicts the effect of the coming edge on the model.
    task automatic cyc(input logic r, input logic [31:0] a, input logic [1:0] s,
                       input logic [31:0] d, input logic rd);
        logic [1:0]  o;
        logic        bad, pop_now, merge, exp_rdy, acc;
        logic [3:0]  st;
        logic [31:0] dd;
        int          n;
        req = r; addr = a; size = s; data = d; ready = rd;
        #1;
        o   = a[1:0];
        bad = (s == 2'b11) || (s == 2'b01 && o[0]) || (s == 2'b10 && o != 2'b00);
        case (s)
            2'b00:   begin dd = {4{d[7:0]}};  st = 4'b0001 << o; end
            2'b01:   begin dd = {2{d[15:0]}}; st = o[1] ? 4'b1100 : 4'b0011; end
            default: begin dd = d;            st = 4'b1111; end
        endcase
        n       = mq.size();
        pop_now = rd && n != 0;
        merge   = !bad && n != 0 && mq[n-1].waddr == {a[31:2], 2'b00} && !(n == 1 && pop_now);
        exp_rdy = (n != DEPTH) || merge;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        acc = r && exp_rdy;
        @(posedge clk);
        if (acc && !bad) begin
            if (merge) begin
                for (int i = 0; i < 4; i++)
                    if (st[i]) mq[$].data[8*i +: 8] = dd[8*i +: 8];
                mq[$].strb = mq[$].strb | st;
            end else begin
                mq.push_back('{waddr: {a[31:2], 2'b00}, strb: st, data: dd});
            end
        end
        exp_mis = acc && bad;
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 1'b0; ready = 1'b0;
        @(posedge clk);
        mq.delete();
        exp_mis = 1'b0;
        #2;
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 4 * DEPTH && mq.size() != 0; k++) cyc(1'b0, 32'h0, 2'b00, 32'h0, 1'b1);
        check("drain_empty", 32'(empty), 32'd1);
    endtask

    initial begin
        int w0;
        rst = 1'b1; req = 1'b0; ready = 1'b0; addr = '0; size = '0; data = '0;
        @(posedge clk);
        do_reset();
        started = 1'b1;

        // Byte store, then pop it.
        cyc(1'b1, 32'h1003, 2'b00, 32'h0000_00AB, 1'b0);
        check("t1_waddr", waddr, 32'h0000_1000);
        check("t1_wstrb", 32'(wstrb), 32'h8);
        check("t1_wdata", wdata, 32'hABAB_ABAB);
        cyc(1'b0, 32'h0, 2'b00, 32'h0, 1'b1);
        check("t1_empty", 32'(empty), 32'd1);

        // Half + byte to the same word merge into one entry.
        cyc(1'b1, 32'h2000, 2'b01, 32'h0000_1234, 1'b0);
        cyc(1'b1, 32'h2003, 2'b00, 32'h0000_0056, 1'b0);
        check("t2_wstrb", 32'(wstrb), 32'hB);
        check("t2_hi", 32'(wdata[31:24]), 32'h56);
        check("t2_lo", 32'(wdata[15:0]), 32'h1234);
        drain();

        // Fill, blocked new word, merge into youngest while full, ordered drain.
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b1, 32'h6000 + 32'(i * 4), 2'b10, 32'h1111_0000 + 32'(i), 1'b0);
        cyc(1'b1, 32'h7000, 2'b00, 32'h0000_0099, 1'b0);
        cyc(1'b1, 32'h600C + 32'h1, 2'b00, 32'h0000_0077, 1'b0);
        drain();

        // Misaligned requests are consumed but never queued.
        cyc(1'b1, 32'h3002, 2'b10, 32'hDEAD_BEEF, 1'b1);
        check("t4_mis_w", 32'(misalign), 32'd1);
        cyc(1'b1, 32'h3001, 2'b01, 32'h0000_BEEF, 1'b1);
        check("t4_mis_h", 32'(misalign), 32'd1);
        cyc(1'b1, 32'h3000, 2'b11, 32'h0000_00EF, 1'b1);
        check("t4_mis_x", 32'(misalign), 32'd1);
        cyc(1'b0, 32'h0, 2'b00, 32'h0, 1'b1);
        check("t4_mis_off", 32'(misalign), 32'd0);
        check("t4_empty", 32'(empty), 32'd1);

        // No merge into a head that is popping this cycle.
        w0 = writes;
        cyc(1'b1, 32'h4000, 2'b00, 32'h0000_0011, 1'b0);
        cyc(1'b1, 32'h4001, 2'b00, 32'h0000_0022, 1'b1);
        check("t5_wstrb", 32'(wstrb), 32'h2);
        drain();
        check("t5_writes", 32'(writes - w0), 32'd2);

        // Reset with entries queued discards them.
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 32'h8000 + 32'(i * 4), 2'b10, 32'(i), 1'b0);
        do_reset();
        check("t6_valid", 32'(valid), 32'd0);
        check("t6_empty", 32'(empty), 32'd1);
        check("t6_mis", 32'(misalign), 32'd0);
        w0 = writes;
        repeat (4) cyc(1'b0, 32'h0, 2'b00, 32'h0, 1'b1);
        check("t6_writes", 32'(writes - w0), 32'd0);

        // Randomized traffic over a few words to exercise merges and stalls.
        for (int c = 0; c < 400; c++) begin
            logic [31:0] a;
            logic [1:0]  s;
            int          sz;
            a  = 32'h5000 + 32'($urandom_range(0, 2) * 4) + 32'($urandom_range(0, 3));
            sz = $urandom_range(0, 9);
            s  = (sz < 3) ? 2'b00 : (sz < 6) ? 2'b01 : (sz < 9) ? 2'b10 : 2'b11;
            cyc(1'($urandom_range(0, 3) != 0), a, s, $urandom, 1'($urandom_range(0, 1)));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write-side counterpart of the load data path. It accepts CPU store requests carrying a byte address, a size and register data. It converts each request into a word-aligned address, a lane-replicated data word and a byte strobe, and queues the results in a small in-order FIFO that drains to the data memory port over a valid/ready handshake. Consecutive stores to the same word are merged into the youngest queued entry, which reduces memory write traffic in front of the accelerator's data memory.

## Interface
- `DEPTH`, default 4: number of queue entries; power of two, ≥2.
- `ADDR_WIDTH`, default 32: byte address width.
- `clk`, input, 1: clock.
- `rst`, input, 1: synchronous, active-high reset.
- `req`, input, 1: store request valid.
- `req_ready`, output, 1: store request accepted this cycle when `req & req_ready`.
- `addr`, input, ADDR_WIDTH: store byte address.
- `size`, input, 2: 00 byte, 01 half, 10 word, 11 illegal.
- `data`, input, 32: store data, right-justified.
- `valid`, output, 1: head entry presented to memory.
- `ready`, input, 1: memory accepts head entry when `valid & ready`.
- `waddr`, output, ADDR_WIDTH: head word address, with [1:0] forced to 0.
- `wstrb`, output, 4: head byte strobe.
- `wdata`, output, 32: head aligned data.
- `empty`, output, 1: queue holds no entries.
- `misalign`, output, 1: one-cycle pulse reporting that an accepted request was dropped.

## Operation
- Lane generation per request, with `off` = addr[1:0]:
  - byte: data `{4{data[7:0]}}`, strobe `1<<off`.
  - half: data `{2{data[15:0]}}`, strobe 0011 when off[1]=0, 1100 when off[1]=1.
  - word: data `data`, strobe 1111.
- Misaligned request conditions: half with off[0]=1; word with off≠0; size 11.
  - Consumes the handshake: it is accepted when `req_ready`.
  - Never written to the queue.
  - Raises `misalign` on the next cycle.
- Queue: circular buffer of DEPTH entries {word addr, strobe, data}, with head/tail pointers and a count of width $clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Merge hit: all of the following hold.
  - The request is aligned.
  - Count > 0.
  - addr[ADDR_WIDTH-1:2] equals the youngest entry's word address.
  - It is NOT the case that the youngest entry is also the head (count==1) while `valid & ready` pops it this cycle.
- On a merge: for each lane i where the new strobe is set, entry data byte i is replaced and strobe bit i is set. Count and tail are unchanged.
- Otherwise an aligned accepted request is pushed at the tail.
- `req_ready = (count != DEPTH) | merge_hit`.
  - It does not depend on `ready`.
  - When full, a non-merging request waits even if a pop occurs in the same cycle.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- `valid = (count != 0)`.
- `waddr`/`wstrb`/`wdata` come from the head entry register contents. Values are don't-care when `valid=0`.
- Head is held stable while `valid & ~ready`. A merge into the head is permitted only when the head is not being popped; the merged value becomes visible the following cycle.
- Ordering: strictly in program order. A merge never reorders entries because it targets only the youngest entry.

## Timing
- Reset values: count 0, pointers 0, `valid` 0, `empty` 1, `misalign` 0. `req_ready` is 1 after reset.
- Reset asserted mid-operation discards all entries on the next edge. No partial write is issued after reset.
- Latency: a store accepted at edge N appears at the output (`valid`=1 if the queue was empty) in the cycle after edge N. The queue has no combinational bypass from `req` to `valid`.
- Throughput: one push and one pop per cycle.
- `misalign` is registered: high exactly one cycle after the accepting edge.
- `empty` equals `~valid`.

## Test plan
- Reset, then a byte store with addr=0x1003, data=0xAB → next cycle: `valid`=1, `waddr`=0x1000, `wstrb`=1000, `wdata`=0xABABABAB. With `ready`=1 the entry pops and `empty`=1.
- With `ready` held 0: half store 0x2000 data 0x1234, then byte store 0x2003 data 0x56 → a single entry with `wstrb`=1011 and `wdata`[31:24]=0x56, [15:0]=0x1234.
- Fill DEPTH=4 distinct words with `ready`=0 → `req_ready`=0 for a new word. A store to the 4th word's address is still accepted (merge). After `ready`=1, entries drain in order.
- Word store to 0x3002 → no entry queued; `misalign`=1 for exactly one cycle; `empty` stays 1. The same applies to a half store at 0x3001 and to size=11.
- One entry at 0x4000 being popped (`ready`=1) while a byte store to 0x4001 arrives → no merge. A new entry with `wstrb`=0010 is queued; the memory side sees two writes.
- Assert `rst` with 3 entries queued → next cycle: `valid`=0, `empty`=1, `misalign`=0, and no further writes are presented.
